// File: rtl/prog_cntr_unit.sv
// prog_cntr_unit: program counter with trap/mret/jump/increment selection, misalign detect and retired-instruction counter
module prog_cntr_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INC_BYTES = 4,
  parameter int ALIGN_BITS = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             mret,
  input  logic             ld,
  input  logic [WIDTH-1:0] data,
  input  logic             inc,
  input  logic             retire,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] prev_count,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic [WIDTH-1:0] bad_addr,
  output logic [CNT_W-1:0] instret
);
  localparam logic [WIDTH-1:0] AMASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
  logic             ld_eff;
  logic             bad_ld;
  logic             upd;
  logic [WIDTH-1:0] next_count;
  always_comb begin
    ld_eff     = ld & ~trap & ~mret;
    bad_ld     = ld_eff & |(data & ~AMASK);
    upd        = trap | mret | (ld_eff & ~bad_ld) | (~trap & ~mret & ~ld & inc);
    next_count = trap ? (trap_vec & AMASK) :
                 mret ? epc :
                 ld   ? data :
                        count + WIDTH'(INC_BYTES);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= RESET_VECTOR;
      prev_count <= RESET_VECTOR;
      epc        <= '0;
      misalign   <= 1'b0;
      bad_addr   <= '0;
      instret    <= '0;
    end else begin
      if (upd) begin
        count      <= next_count;
        prev_count <= count;
      end
      if (trap) epc <= count & AMASK;
      misalign <= bad_ld;
      if (bad_ld) bad_addr <= data;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_prog_cntr_unit.sv
// tb_prog_cntr_unit: directed self-checking bench for prog_cntr_unit
module tb_prog_cntr_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trap = 1'b0, mret = 1'b0, ld = 1'b0, inc = 1'b0, retire = 1'b0;
  logic [31:0] trap_vec = '0, data = '0;
  logic [31:0] count, prev_count, epc, bad_addr;
  logic [31:0] count_b, prev_count_b, epc_b, bad_addr_b;
  logic        misalign, misalign_b;
  logic [63:0] instret;
  logic [3:0]  instret_b;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  prog_cntr_unit #(.RESET_VECTOR(32'h0000_0200)) dut (
    .clk(clk), .rst_n(rst_n), .trap(trap), .trap_vec(trap_vec), .mret(mret),
    .ld(ld), .data(data), .inc(inc), .retire(retire), .count(count),
    .prev_count(prev_count), .epc(epc), .misalign(misalign),
    .bad_addr(bad_addr), .instret(instret)
  );
  prog_cntr_unit #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .trap(trap), .trap_vec(trap_vec), .mret(mret),
    .ld(ld), .data(data), .inc(inc), .retire(retire), .count(count_b),
    .prev_count(prev_count_b), .epc(epc_b), .misalign(misalign_b),
    .bad_addr(bad_addr_b), .instret(instret_b)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    trap = 1'b0; mret = 1'b0; ld = 1'b0; inc = 1'b0; retire = 1'b0;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 32'h200);
    chk("rst_prev", prev_count, 32'h200);
    chk("rst_epc", epc, 0);
    chk("rst_instret", instret, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bad_addr", bad_addr, 0);
    chk("rst_b_count", count_b, 0);
    @(negedge clk) rst_n = 1'b1;
    inc = 1'b1;
    tick();
    tick();
    tick();
    chk("inc3_count", count, 32'h20C);
    chk("inc3_prev", prev_count, 32'h208);
    idle();
    tick();
    chk("hold_count", count, 32'h20C);
    chk("hold_prev", prev_count, 32'h208);
    ld = 1'b1; data = 32'hFFFF_FFFC;
    tick();
    chk("ld_top_count", count, 32'hFFFF_FFFC);
    idle(); inc = 1'b1;
    tick();
    chk("wrap_count", count, 32'h0);
    chk("wrap_prev", prev_count, 32'hFFFF_FFFC);
    idle(); ld = 1'b1; data = 32'h1000;
    tick();
    chk("jmp_count", count, 32'h1000);
    chk("jmp_misalign", misalign, 0);
    data = 32'h1002; inc = 1'b1;
    tick();
    chk("mis_count", count, 32'h1000);
    chk("mis_prev", prev_count, 32'h0);
    chk("mis_pulse", misalign, 1);
    chk("mis_bad_addr", bad_addr, 32'h1002);
    idle();
    tick();
    chk("mis_pulse_end", misalign, 0);
    chk("mis_bad_hold", bad_addr, 32'h1002);
    chk("mis_count_hold", count, 32'h1000);
    trap = 1'b1; ld = 1'b1; inc = 1'b1; trap_vec = 32'h0000_0103; data = 32'h5;
    tick();
    chk("trap_count", count, 32'h100);
    chk("trap_epc", epc, 32'h1000);
    chk("trap_prev", prev_count, 32'h1000);
    chk("trap_no_mis", misalign, 0);
    idle(); inc = 1'b1;
    tick();
    tick();
    chk("post_trap_inc", count, 32'h108);
    idle(); mret = 1'b1;
    tick();
    chk("mret_count", count, 32'h1000);
    chk("mret_prev", prev_count, 32'h108);
    chk("mret_epc", epc, 32'h1000);
    ld = 1'b1; data = 32'h3;
    tick();
    chk("mret_ld_count", count, 32'h1000);
    chk("mret_ld_prev", prev_count, 32'h1000);
    chk("mret_ld_no_mis", misalign, 0);
    chk("mret_ld_bad", bad_addr, 32'h1002);
    idle();
    for (int i = 0; i < 5; i++) begin
      retire = 1'b1;
      trap = (i == 2);
      trap_vec = 32'h200;
      tick();
    end
    idle();
    chk("ret5_instret", instret, 5);
    chk("ret5_b_instret", instret_b, 5);
    chk("ret_trap_count", count, 32'h200);
    tick();
    chk("ret_hold", instret, 5);
    retire = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    idle();
    chk("ret16_instret", instret, 16);
    chk("ret16_b_wrap", instret_b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_cntr_unit.md
Name: prog_cntr_unit

Overview:
- Parametrised successor to the core's program-counter register for the multicycle RISC-V datapath.
- Holds the PC plus the PC of the instruction in flight (`prev_count`) and the exception PC (`epc`).
- Performs prioritised next-PC selection: trap entry, `mret` return, jump/branch load, sequential increment.
- Also detects misaligned control-flow targets and keeps a retired-instruction counter; sits between the control FSM and the fetch/ALU paths.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_VECTOR, 32'h0000_0000, value of `count` after reset; must have its ALIGN_BITS LSBs zero.
- INC_BYTES, 4, increment applied on `inc`.
- ALIGN_BITS, 2, number of target LSBs that must be zero (2 = IALIGN32, 1 = compressed).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- trap  in  1  trap entry: `count<=trap_vec`, `epc<=count`
- trap_vec  in  WIDTH  trap handler address (mtvec base)
- mret  in  1  trap return: `count<=epc`
- ld  in  1  load jump/branch target
- data  in  WIDTH  jump/branch target
- inc  in  1  sequential advance: `count<=count+INC_BYTES`
- retire  in  1  instruction retired this cycle
- count  out  WIDTH  current PC
- prev_count  out  WIDTH  PC before the most recent update
- epc  out  WIDTH  saved exception PC
- misalign  out  1  one-cycle pulse: last `ld` target misaligned
- bad_addr  out  WIDTH  last misaligned target (mtval source)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async assert on `rst_n`=0, sync-safe release): `count`=RESET_VECTOR, `prev_count`=RESET_VECTOR, `epc`=0, `misalign`=0, `bad_addr`=0, `instret`=0. Reset mid-update wins unconditionally; the in-flight update is lost.
- All outputs are registered. Latency is one clock from request to new `count`.
- Update priority per cycle, one action only: `trap` > `mret` > `ld` > `inc`. If none is asserted, `count` holds.
- Any action that changes `count` also sets `prev_count<=count` (old value). On hold, `prev_count` is unchanged.
- trap:
  - `count<=trap_vec` with the ALIGN_BITS LSBs forced to 0.
  - `epc<=count` with the ALIGN_BITS LSBs forced to 0.
  - A simultaneous `mret`/`ld`/`inc` is ignored.
- mret: `count<=epc`. `epc` is unchanged.
- ld, aligned target (`data[ALIGN_BITS-1:0]`==0): `count<=data`.
- ld, misaligned target:
  - `count` and `prev_count` hold; `inc` in the same cycle is also suppressed.
  - `bad_addr<=data`; `misalign`=1 in the next cycle only.
  - The control FSM converts the pulse into a trap.
- ld masked by `trap` or `mret`: no alignment check, no `misalign`.
- `misalign` returns to 0 in every cycle not directly following a misaligned `ld`. `bad_addr` holds until the next misaligned `ld`.
- inc: `count<=count+INC_BYTES`, modulo 2^WIDTH; wrap from all-ones region to low addresses is silent, no flag.
- retire:
  - Independent of PC actions; `instret<=instret+1` modulo 2^CNT_W, wrapping to 0 silently.
  - Counts in any cycle `retire`=1, including cycles with `trap`.
- Arithmetic is unsigned, WIDTH bits, carry discarded.

Test Plan:
- Reset: assert `rst_n`=0 between clock edges with RESET_VECTOR=32'h0000_0200 -> `count`=`prev_count`=32'h200, `epc`=0, `instret`=0 immediately, without waiting for a clock edge.
- Sequence: `inc` ×3 from 32'h200 -> `count`=32'h20C, `prev_count`=32'h208. With `count`=32'hFFFF_FFFC, `inc` -> `count`=0, `prev_count`=32'hFFFF_FFFC.
- Jump: `ld`, `data`=32'h0000_1000 -> `count`=32'h1000, `misalign`=0. `ld`, `data`=32'h0000_1002 with `inc`=1 -> `count` stays 32'h1000, `misalign`=1 for exactly one cycle, `bad_addr`=32'h1002.
- Trap/return: `count`=32'h1000; `trap`+`ld`+`inc` together with `trap_vec`=32'h0000_0103 -> `count`=32'h100, `epc`=32'h1000, `prev_count`=32'h1000. Then `inc` ×2, then `mret` -> `count`=32'h1000, `prev_count`=32'h108.
- Priority/misalign masking: `mret`+`ld`(`data`=32'h3) -> `count`=`epc`, `misalign` stays 0, `bad_addr` unchanged.
- Counter: preload-free run of 5 `retire` pulses, including one coinciding with `trap` -> `instret`=5. With CNT_W=4, 16 `retire` pulses -> `instret`=0.
